// File: rtl/sum_lt_alarm_monitor.sv
// -----------------------------------------------------------------------------
// sum_lt_alarm_monitor
//
// Purpose:
//   Accepts operand triples (a, b, thr) over a valid/ready handshake and
//   computes lt = (a + b) < thr in a two-stage pipeline. Each result is
//   delivered over a second valid/ready handshake. A hysteresis FSM watches
//   the delivered results. It raises alarm after HIT_COUNT consecutive lt=1
//   results, and it drops alarm after MISS_COUNT consecutive lt=0 results.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   clear      in   1      synchronous flush of pipeline, FSM and counters
//   in_valid   in   1      operand triple valid
//   in_ready   out  1      block can accept a triple (combinational)
//   in1        in   3      operand a (unsigned)
//   in2        in   4      operand b (unsigned)
//   in3        in   9      threshold (unsigned)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   out_lt     out  1      1 when in1 + in2 < in3 for that triple
//   alarm      out  1      hysteresis alarm state
//   hit_run    out  CNT_W  consecutive lt=1 result count (saturating)
// -----------------------------------------------------------------------------
module sum_lt_alarm_monitor #(
  parameter int HIT_COUNT  = 4,
  parameter int MISS_COUNT = 2,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in1,
  input  logic [3:0]       in2,
  input  logic [8:0]       in3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_lt,
  output logic             alarm,
  output logic [CNT_W-1:0] hit_run
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] HIT_TGT  = CNT_W'(HIT_COUNT);
  localparam logic [CNT_W-1:0] MISS_TGT = CNT_W'(MISS_COUNT);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ALARM = 1'b1
  } state_t;

  // Saturating increment. The run counters stick at all-ones rather than wrap.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    if (v == CNT_MAX) begin
      r = v;
    end else begin
      r = v + CNT_ONE;
    end
    return r;
  endfunction

  // Stage 1 holds the raw operands. Stage 2 holds the comparison result.
  logic             s1_valid_r;
  logic [2:0]       s1_a_r;
  logic [3:0]       s1_b_r;
  logic [8:0]       s1_thr_r;
  logic             s2_valid_r;
  logic             s2_lt_r;

  logic             s2_load_s;
  logic             s1_load_s;
  logic             event_s;
  logic [4:0]       sum_s;
  logic             lt_s;
  logic [CNT_W-1:0] hit_inc_s;
  logic [CNT_W-1:0] miss_inc_s;

  state_t           state_r;
  logic             alarm_r;
  logic [CNT_W-1:0] hit_r;
  logic [CNT_W-1:0] miss_r;

  // Handshake control, and the compare that sits between S1 and S2.
  always_comb begin
    s2_load_s  = !s2_valid_r || out_ready;
    s1_load_s  = !s1_valid_r || s2_load_s;
    in_ready   = !clear && s1_load_s;
    event_s    = s2_valid_r && out_ready;
    // The largest sum is 7 + 15 = 22, so 5 bits never overflow.
    sum_s      = {2'b00, s1_a_r} + {1'b0, s1_b_r};
    // Compare unsigned after zero-extending the sum. Equality gives 0.
    lt_s       = ({4'b0000, sum_s} < s1_thr_r);
    hit_inc_s  = sat_inc(hit_r);
    miss_inc_s = sat_inc(miss_r);
  end

  // Pipeline stage registers. A flush drops both stages, and it wins over
  // any handshake in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_a_r     <= 3'd0;
      s1_b_r     <= 4'd0;
      s1_thr_r   <= 9'd0;
      s2_valid_r <= 1'b0;
      s2_lt_r    <= 1'b0;
    end else if (clear) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      if (s2_load_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          s2_lt_r <= lt_s;
        end
      end
      if (s1_load_s) begin
        s1_valid_r <= in_valid;
        if (in_valid) begin
          s1_a_r   <= in1;
          s1_b_r   <= in2;
          s1_thr_r <= in3;
        end
      end
    end
  end

  // Hysteresis FSM. It advances only on a delivered result, so alarm and
  // hit_run change in the cycle after that result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      alarm_r <= 1'b0;
      hit_r   <= CNT_ZERO;
      miss_r  <= CNT_ZERO;
    end else if (clear) begin
      state_r <= ST_IDLE;
      alarm_r <= 1'b0;
      hit_r   <= CNT_ZERO;
      miss_r  <= CNT_ZERO;
    end else if (event_s) begin
      case (state_r)
        ST_IDLE: begin
          miss_r <= CNT_ZERO;
          if (s2_lt_r) begin
            hit_r <= hit_inc_s;
            // The >= test keeps a small HIT_COUNT safe when the count saturates.
            if (hit_inc_s >= HIT_TGT) begin
              state_r <= ST_ALARM;
              alarm_r <= 1'b1;
            end
          end else begin
            hit_r <= CNT_ZERO;
          end
        end
        ST_ALARM: begin
          if (s2_lt_r) begin
            miss_r <= CNT_ZERO;
            hit_r  <= hit_inc_s;
          end else if (miss_inc_s >= MISS_TGT) begin
            state_r <= ST_IDLE;
            alarm_r <= 1'b0;
            hit_r   <= CNT_ZERO;
            miss_r  <= CNT_ZERO;
          end else begin
            miss_r <= miss_inc_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          alarm_r <= 1'b0;
          hit_r   <= CNT_ZERO;
          miss_r  <= CNT_ZERO;
        end
      endcase
    end
  end

  assign out_valid = s2_valid_r;
  assign out_lt    = s2_lt_r;
  assign alarm     = alarm_r;
  assign hit_run   = hit_r;

endmodule

// File: tb/tb_sum_lt_alarm_monitor.sv
// -----------------------------------------------------------------------------
// tb_sum_lt_alarm_monitor
//
// Purpose:
//   Directed self-checking bench for sum_lt_alarm_monitor, which uses the
//   default parameters (HIT_COUNT=4, MISS_COUNT=2, CNT_W=4). The bench drives
//   inputs and samples outputs on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_sum_lt_alarm_monitor;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in1;
  logic [3:0] in2;
  logic [8:0] in3;
  logic       out_valid;
  logic       out_ready;
  logic       out_lt;
  logic       alarm;
  logic [3:0] hit_run;

  int compared;
  int mismatched;

  sum_lt_alarm_monitor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lt    (out_lt),
    .alarm     (alarm),
    .hit_run   (hit_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Move to the falling edge that follows the next rising edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Send one triple with out_ready held high. The task checks latency, the
  // result, and the counter and alarm state after the result event.
  task automatic send(input string tag, input logic [2:0] a, input logic [3:0] b,
                      input logic [8:0] t, input logic exp_lt,
                      input logic [3:0] exp_hit, input logic exp_alarm);
    in1 = a; in2 = b; in3 = t; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check({tag, "_vld_n1"}, out_valid, 1'b0);
    tick();
    check({tag, "_vld_n2"}, out_valid, 1'b1);
    check({tag, "_lt"}, out_lt, exp_lt);
    tick();
    check({tag, "_vld_after"}, out_valid, 1'b0);
    check_cnt({tag, "_hit"}, hit_run, exp_hit);
    check({tag, "_alarm"}, alarm, exp_alarm);
  endtask

  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = 3'd0; in2 = 4'd0; in3 = 9'd0;

    // Reset state
    #3;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_lt", out_lt, 1'b0);
    check("rst_alarm", alarm, 1'b0);
    check_cnt("rst_hit_run", hit_run, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: 3+4=7 < 8 gives 1, and 7 < 7 gives 0
    send("t1a", 3'd3, 4'd4, 9'd8, 1'b1, 4'd1, 1'b0);
    send("t1b", 3'd3, 4'd4, 9'd7, 1'b0, 4'd0, 1'b0);

    // Test 2: arithmetic bounds
    send("t2_23",  3'd7, 4'd15, 9'd23,  1'b1, 4'd1, 1'b0);
    send("t2_001", 3'd0, 4'd0,  9'd1,   1'b1, 4'd2, 1'b0);
    send("t2_511", 3'd7, 4'd15, 9'd511, 1'b1, 4'd3, 1'b0);
    send("t2_22",  3'd7, 4'd15, 9'd22,  1'b0, 4'd0, 1'b0);
    send("t2_000", 3'd0, 4'd0,  9'd0,   1'b0, 4'd0, 1'b0);

    // Test 3: four back-to-back lt=1 triples at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4);
      in1 = 3'd0; in2 = 4'd0; in3 = 9'd5;
      tick();
      if (i >= 2) begin
        check_cnt("t3_hit_run", hit_run, 4'(i - 1));
        check("t3_alarm", alarm, (i >= 5));
      end
    end
    in_valid = 1'b0;
    // Two lt=0 results back to back clear the alarm.
    in1 = 3'd7; in2 = 4'd15; in3 = 9'd22; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("t3_drop_vld", out_valid, 1'b1);
    check("t3_drop_lt", out_lt, 1'b0);
    tick();
    check("t3_alarm_after_miss1", alarm, 1'b1);
    check_cnt("t3_hit_after_miss1", hit_run, 4'd4);
    tick();
    check("t3_alarm_after_miss2", alarm, 1'b0);
    check_cnt("t3_hit_after_miss2", hit_run, 4'd0);

    // Test 4: a lt=1 between two lt=0 resets the miss run
    send("t4_h1", 3'd1, 4'd1, 9'd3, 1'b1, 4'd1, 1'b0);
    send("t4_h2", 3'd1, 4'd1, 9'd3, 1'b1, 4'd2, 1'b0);
    send("t4_h3", 3'd1, 4'd1, 9'd3, 1'b1, 4'd3, 1'b0);
    send("t4_h4", 3'd1, 4'd1, 9'd3, 1'b1, 4'd4, 1'b1);
    send("t4_m1", 3'd1, 4'd1, 9'd2, 1'b0, 4'd4, 1'b1);
    send("t4_h5", 3'd1, 4'd1, 9'd3, 1'b1, 4'd5, 1'b1);
    send("t4_m2", 3'd1, 4'd1, 9'd2, 1'b0, 4'd5, 1'b1);
    send("t4_m3", 3'd1, 4'd1, 9'd2, 1'b0, 4'd0, 1'b0);

    // Test 5: stall with three triples offered
    out_ready = 1'b0;
    in1 = 3'd0; in2 = 4'd0; in3 = 9'd1; in_valid = 1'b1;     // T1, lt=1
    #1;
    check("t5_rdy_t1", in_ready, 1'b1);
    tick();
    in1 = 3'd7; in2 = 4'd15; in3 = 9'd22;                   // T2, lt=0
    #1;
    check("t5_rdy_t2", in_ready, 1'b1);
    tick();
    in1 = 3'd0; in2 = 4'd0; in3 = 9'd2;                     // T3, lt=1
    #1;
    check("t5_rdy_t3", in_ready, 1'b0);
    check("t5_vld_stall", out_valid, 1'b1);
    check("t5_lt_stall", out_lt, 1'b1);
    tick();
    tick();
    check("t5_rdy_hold", in_ready, 1'b0);
    check("t5_vld_hold", out_valid, 1'b1);
    check("t5_lt_hold", out_lt, 1'b1);
    check_cnt("t5_hit_hold", hit_run, 4'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("t5_rel_vld1", out_valid, 1'b1);
    check("t5_rel_lt1", out_lt, 1'b0);
    check_cnt("t5_rel_hit1", hit_run, 4'd1);
    tick();
    check("t5_rel_vld2", out_valid, 1'b0);
    check_cnt("t5_rel_hit2", hit_run, 4'd0);

    // Test 6: clear with both stages full and the alarm set
    send("t6_h1", 3'd0, 4'd0, 9'd1, 1'b1, 4'd1, 1'b0);
    send("t6_h2", 3'd0, 4'd0, 9'd1, 1'b1, 4'd2, 1'b0);
    send("t6_h3", 3'd0, 4'd0, 9'd1, 1'b1, 4'd3, 1'b0);
    send("t6_h4", 3'd0, 4'd0, 9'd1, 1'b1, 4'd4, 1'b1);
    out_ready = 1'b0;
    in1 = 3'd0; in2 = 4'd0; in3 = 9'd1; in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("t6_full_vld", out_valid, 1'b1);
    clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    #1;
    check("t6_rdy_clear", in_ready, 1'b0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("t6_vld_clr", out_valid, 1'b0);
    check("t6_alarm_clr", alarm, 1'b0);
    check_cnt("t6_hit_clr", hit_run, 4'd0);
    tick();
    check("t6_vld_clr2", out_valid, 1'b0);
    check_cnt("t6_hit_clr2", hit_run, 4'd0);

    // Asynchronous reset in the middle of a stream
    send("t6_pre", 3'd0, 4'd0, 9'd1, 1'b1, 4'd1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    check("t6_pre_vld", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_arst_vld", out_valid, 1'b0);
    check("t6_arst_lt", out_lt, 1'b0);
    check("t6_arst_alarm", alarm, 1'b0);
    check_cnt("t6_arst_hit", hit_run, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t6_post_vld", out_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
